// File: rtl/writeback_stage.sv
// Writeback stage: holds one retired-instruction entry, drives the register-file
// write port, a forwarding copy, a registered output port and a retire counter.
module writeback_stage #(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [59:0]        MemoryOutput,
    input  logic               InValid,
    input  logic               Stall,
    input  logic               Flush,
    output logic               RegWrite,
    output logic [2:0]         RegAddr,
    output logic [15:0]        RegData,
    output logic               FwdValid,
    output logic [2:0]         FwdAddr,
    output logic [15:0]        FwdData,
    output logic [15:0]        OutPort,
    output logic               OutPortStrobe,
    output logic [COUNT_W-1:0] RetiredCount
);

    localparam int BUNDLE_W = 60;

    logic                vld_p0;
    logic                cmt_p0;
    logic [BUNDLE_W-1:0] bundle_p0;

    logic [15:0] aux_p0;
    logic [15:0] memdata_p0;
    logic [15:0] aluout_p0;
    logic [2:0]  rdst_p0;
    logic        outen_p0;
    logic [1:0]  wbsel_p0;
    logic        regwr_p0;
    logic [15:0] result_p0;
    logic        commit_p0;
    logic        unused_p0;

    function automatic logic [15:0] wb_select(input logic [1:0]  sel,
                                              input logic [15:0] alu,
                                              input logic [15:0] mem,
                                              input logic [15:0] aux);
        logic [15:0] r;
        case (sel)
            2'b01:   r = mem;
            2'b10:   r = aux;
            default: r = alu;
        endcase
        return r;
    endfunction

    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] c);
        return c + COUNT_W'(1);
    endfunction

    // Stage p0: the held writeback entry
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            vld_p0    <= 1'b0;
            cmt_p0    <= 1'b0;
            bundle_p0 <= '0;
        end else if (Flush) begin
            vld_p0 <= 1'b0;
            cmt_p0 <= 1'b0;
        end else if (Stall) begin
            cmt_p0 <= cmt_p0 | commit_p0;
        end else begin
            vld_p0    <= InValid;
            cmt_p0    <= 1'b0;
            bundle_p0 <= MemoryOutput;
        end
    end

    assign aux_p0     = bundle_p0[57:42];
    assign memdata_p0 = bundle_p0[41:26];
    assign aluout_p0  = bundle_p0[25:10];
    assign rdst_p0    = bundle_p0[9:7];
    assign outen_p0   = bundle_p0[3];
    assign wbsel_p0   = bundle_p0[2:1];
    assign regwr_p0   = bundle_p0[0];
    // SpOp, MemRead and the reserved field ride along without steering anything
    assign unused_p0  = ^{bundle_p0[59:58], bundle_p0[6:4]};

    // An entry commits once: the first cycle it is valid, however long it then stalls
    assign commit_p0 = vld_p0 & ~cmt_p0;
    assign result_p0 = wb_select(wbsel_p0, aluout_p0, memdata_p0, aux_p0);

    assign RegWrite = Reset & commit_p0 & regwr_p0;
    assign RegAddr  = Reset ? rdst_p0   : 3'd0;
    assign RegData  = Reset ? result_p0 : 16'd0;
    assign FwdValid = Reset & vld_p0 & regwr_p0;
    assign FwdAddr  = rdst_p0;
    assign FwdData  = result_p0;

    // Stage p1: side effects of a commit (output port and retire count)
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            OutPort       <= 16'd0;
            OutPortStrobe <= 1'b0;
            RetiredCount  <= '0;
        end else begin
            OutPortStrobe <= commit_p0 & outen_p0;
            if (commit_p0 & outen_p0)
                OutPort <= result_p0;
            if (commit_p0)
                RetiredCount <= count_inc(RetiredCount);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: a behavioural model of "one instruction
// held, written once, counted once" checked every cycle, plus literal scenarios.
module tb_writeback_stage;

    localparam int CW  = 8;
    localparam int MOD = 1 << CW;

    logic          CLK;
    logic          Reset;
    logic [59:0]   MemoryOutput;
    logic          InValid;
    logic          Stall;
    logic          Flush;
    logic          RegWrite;
    logic [2:0]    RegAddr;
    logic [15:0]   RegData;
    logic          FwdValid;
    logic [2:0]    FwdAddr;
    logic [15:0]   FwdData;
    logic [15:0]   OutPort;
    logic          OutPortStrobe;
    logic [CW-1:0] RetiredCount;

    writeback_stage #(.COUNT_W(CW)) dut (
        .CLK(CLK), .Reset(Reset), .MemoryOutput(MemoryOutput), .InValid(InValid),
        .Stall(Stall), .Flush(Flush), .RegWrite(RegWrite), .RegAddr(RegAddr),
        .RegData(RegData), .FwdValid(FwdValid), .FwdAddr(FwdAddr), .FwdData(FwdData),
        .OutPort(OutPort), .OutPortStrobe(OutPortStrobe), .RetiredCount(RetiredCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 1'b0;

    // Model: the instruction currently in writeback and whether it has already retired
    bit          m_valid;
    bit          m_done;
    logic [59:0] m_bundle;
    int          m_count;
    logic [15:0] m_out;
    bit          m_strobe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [59:0] mk(input bit spop, input bit memrd, input logic [15:0] aux,
                                       input logic [15:0] memd, input logic [15:0] alu,
                                       input logic [2:0] rdst, input bit outen,
                                       input logic [1:0] wbsel, input bit regwr);
        return {spop, memrd, aux, memd, alu, rdst, 3'b000, outen, wbsel, regwr};
    endfunction

    function automatic logic [15:0] value_of(input logic [59:0] b);
        if (b[2:1] == 2'b01) return b[41:26];
        if (b[2:1] == 2'b10) return b[57:42];
        return b[25:10];
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_done   = 0;
        m_bundle = '0;
        m_count  = 0;
        m_out    = 16'd0;
        m_strobe = 0;
    endtask

    task automatic model_step();
        bit retire;
        retire   = m_valid && !m_done;
        m_strobe = retire && m_bundle[3];
        if (retire) m_count = (m_count + 1) % MOD;
        if (m_strobe) m_out = value_of(m_bundle);
        if (Flush) begin
            m_valid = 0;
            m_done  = 0;
        end else if (Stall) begin
            if (retire) m_done = 1;
        end else begin
            m_valid  = InValid;
            m_done   = 0;
            m_bundle = MemoryOutput;
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            logic ew, ef;
            ew = m_valid && !m_done && m_bundle[0];
            ef = m_valid && m_bundle[0];
            chk("RegWrite", 32'(RegWrite), 32'(ew));
            chk("FwdValid", 32'(FwdValid), 32'(ef));
            if (ew) begin
                chk("RegAddr", 32'(RegAddr), 32'(m_bundle[9:7]));
                chk("RegData", 32'(RegData), 32'(value_of(m_bundle)));
            end
            if (ef) begin
                chk("FwdAddr", 32'(FwdAddr), 32'(m_bundle[9:7]));
                chk("FwdData", 32'(FwdData), 32'(value_of(m_bundle)));
            end
            chk("OutPort", 32'(OutPort), 32'(m_out));
            chk("OutPortStrobe", 32'(OutPortStrobe), 32'(m_strobe));
            chk("RetiredCount", 32'(RetiredCount), 32'(m_count));
        end
    end

    // Apply one cycle of inputs, clock it, return just after the following falling edge
    task automatic cyc(input bit inv, input logic [59:0] b, input bit st, input bit fl);
        InValid      = inv;
        MemoryOutput = b;
        Stall        = st;
        Flush        = fl;
        @(posedge CLK);
        if (Reset) model_step();
        @(negedge CLK);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, " RegWrite"}, 32'(RegWrite), 32'd0);
        chk({tag, " FwdValid"}, 32'(FwdValid), 32'd0);
        chk({tag, " RegAddr"}, 32'(RegAddr), 32'd0);
        chk({tag, " RegData"}, 32'(RegData), 32'd0);
        chk({tag, " OutPort"}, 32'(OutPort), 32'd0);
        chk({tag, " OutPortStrobe"}, 32'(OutPortStrobe), 32'd0);
        chk({tag, " RetiredCount"}, 32'(RetiredCount), 32'd0);
    endtask

    initial begin
        logic [59:0] b;
        logic [63:0] r;
        int c0;

        Reset = 1'b0;
        InValid = 1'b0;
        MemoryOutput = '0;
        Stall = 1'b0;
        Flush = 1'b0;
        model_reset();
        #2;
        all_zero("reset");
        @(negedge CLK);
        Reset = 1'b1;
        chk_en = 1'b1;

        // ALU writeback, then counted one edge later
        cyc(1, mk(0, 0, 16'h0, 16'h0, 16'h1234, 3'd5, 0, 2'b00, 1), 0, 0);
        chk("alu RegWrite", 32'(RegWrite), 32'd1);
        chk("alu RegAddr", 32'(RegAddr), 32'd5);
        chk("alu RegData", 32'(RegData), 32'h1234);
        chk("alu count before", 32'(RetiredCount), 32'd0);
        cyc(0, '0, 0, 0);
        chk("alu count after", 32'(RetiredCount), 32'd1);
        chk("alu RegWrite after", 32'(RegWrite), 32'd0);

        // Load held for three stall cycles writes once; MemRead also set here
        cyc(1, mk(0, 1, 16'h0, 16'hBEEF, 16'h1111, 3'd2, 0, 2'b01, 1), 0, 0);
        chk("ld RegWrite first", 32'(RegWrite), 32'd1);
        chk("ld RegData", 32'(RegData), 32'hBEEF);
        chk("ld FwdValid first", 32'(FwdValid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, '1, 1, 0);
            chk("ld RegWrite stalled", 32'(RegWrite), 32'd0);
            chk("ld FwdValid stalled", 32'(FwdValid), 32'd1);
            chk("ld FwdData stalled", 32'(FwdData), 32'hBEEF);
        end
        chk("ld count", 32'(RetiredCount), 32'd2);

        // MemRead with WbSel=00 still takes AluOut
        cyc(1, mk(1, 1, 16'h7777, 16'h5555, 16'h4321, 3'd6, 0, 2'b00, 1), 0, 0);
        chk("memrd alu RegData", 32'(RegData), 32'h4321);

        // Flush+Stall over an already-committed entry
        cyc(1, mk(0, 0, 16'h0, 16'h0, 16'h00AA, 3'd1, 0, 2'b00, 1), 0, 0);
        cyc(0, '0, 1, 0);
        c0 = int'(RetiredCount);
        cyc(1, '1, 1, 1);
        chk("flush RegWrite", 32'(RegWrite), 32'd0);
        chk("flush FwdValid", 32'(FwdValid), 32'd0);
        chk("flush count", 32'(RetiredCount), 32'(c0));

        // Flush+Stall on the commit edge: commit still counts
        cyc(1, mk(0, 0, 16'h0, 16'h0, 16'h00BB, 3'd4, 0, 2'b00, 1), 0, 0);
        c0 = int'(RetiredCount);
        cyc(1, '1, 1, 1);
        chk("flush commit count", 32'(RetiredCount), 32'((c0 + 1) % MOD));
        chk("flush commit FwdValid", 32'(FwdValid), 32'd0);

        // Output port from Aux16
        cyc(1, mk(0, 0, 16'h00A5, 16'h0, 16'h0, 3'd0, 1, 2'b10, 0), 0, 0);
        chk("out strobe early", 32'(OutPortStrobe), 32'd0);
        cyc(0, '0, 0, 0);
        chk("out OutPort", 32'(OutPort), 32'h00A5);
        chk("out strobe", 32'(OutPortStrobe), 32'd1);
        cyc(0, '0, 0, 0);
        chk("out strobe drop", 32'(OutPortStrobe), 32'd0);
        chk("out held", 32'(OutPort), 32'h00A5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = {$urandom, $urandom};
            b = r[59:0];
            cyc(1'($urandom_range(0, 3) != 0), b, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        end

        // Asynchronous reset mid-stall with a committed entry and OutPort=0x0F0F
        cyc(1, mk(0, 0, 16'h0F0F, 16'h0, 16'h0, 3'd3, 1, 2'b10, 1), 0, 0);
        cyc(1, mk(0, 0, 16'h0, 16'h0, 16'h2222, 3'd7, 0, 2'b00, 1), 0, 0);
        cyc(0, '0, 1, 0);
        chk("pre-reset OutPort", 32'(OutPort), 32'h0F0F);
        #2;
        Reset = 1'b0;
        #1;
        all_zero("async");
        model_reset();
        @(negedge CLK);
        Reset = 1'b1;
        cyc(0, '0, 1, 0);
        chk("post-reset stalled RegWrite", 32'(RegWrite), 32'd0);
        cyc(0, '0, 0, 0);
        chk("post-reset RegWrite", 32'(RegWrite), 32'd0);
        cyc(1, mk(0, 0, 16'h0, 16'h0, 16'h0C0C, 3'd2, 0, 2'b11, 1), 0, 0);
        chk("post-reset load RegData", 32'(RegData), 32'h0C0C);

        // Counter wrap from 2^CW-1 to 0
        #2;
        Reset = 1'b0;
        model_reset();
        @(negedge CLK);
        Reset = 1'b1;
        for (int i = 0; i < MOD - 1; i++) begin
            r = {$urandom, $urandom};
            cyc(1, r[59:0], 0, 0);
        end
        cyc(0, '0, 0, 0);
        chk("wrap preload", 32'(RetiredCount), 32'(MOD - 1));
        cyc(1, '0, 0, 0);
        cyc(0, '0, 0, 0);
        chk("wrap to zero", 32'(RetiredCount), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
